// File: rtl/life_pkg.sv
// Shared types and constants for the grid sequencer slice: grid width,
// step-timer width, sequencer state encoding and halt-cause encoding.
package life_pkg;

    localparam int unsigned GRID_W  = 64;
    localparam int unsigned TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_STOP    = 2'b00,
        CAUSE_MAXGEN  = 2'b01,
        CAUSE_STABLE  = 2'b10,
        CAUSE_EXTINCT = 2'b11
    } cause_t;

endpackage

// File: rtl/grid_sequencer_if.sv
// Request/response bundle between a controller (master) and the grid
// sequencer (slave), including the evolve-datapath loop (grid out,
// grid_evolve back in).
interface grid_sequencer_if #(
    parameter int unsigned GEN_W = 16
) ();
    import life_pkg::*;

    logic [GRID_W-1:0] seed;
    logic              load;
    logic              start;
    logic              stop;
    logic              step;
    logic [GEN_W-1:0]  max_gen;
    logic [GRID_W-1:0] grid_evolve;
    logic [GRID_W-1:0] grid;
    logic [GEN_W-1:0]  gen_count;
    logic              gen_valid;
    logic              busy;
    logic              done;
    logic [1:0]        done_cause;

    modport master (
        output seed, load, start, stop, step, max_gen, grid_evolve,
        input  grid, gen_count, gen_valid, busy, done, done_cause
    );

    modport slave (
        input  seed, load, start, stop, step, max_gen, grid_evolve,
        output grid, gen_count, gen_valid, busy, done, done_cause
    );

endinterface

// File: rtl/step_timer.sv
// Commit cadence counter: while enabled, raises o_tick on every
// STEP_DIV-th cycle, the first one STEP_DIV cycles after enable rises.
module step_timer
    import life_pkg::*;
#(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(STEP_DIV - 1);

    logic [TIMER_W-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == LAST);

    // Count cycles while enabled; restart after each tick, on clear, or when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_enable || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/grid_sequencer.sv
// Game-of-life generation sequencer: loads a seed, then commits the
// externally computed next generation on step-timer ticks (RUN) or on
// single-step requests, tracking generation count and halt cause.
// Optional GRID_HALT_DETECT_EN adds extinct/stable automatic halting.
module grid_sequencer
    import life_pkg::*;
#(
    parameter int unsigned GEN_W    = 16,
    parameter int unsigned STEP_DIV = 1
) (
    input logic             clk,
    input logic             reset_n,
    grid_sequencer_if.slave bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic [GRID_W-1:0] r_grid;
    logic [GRID_W-1:0] w_grid_next;
    logic [GEN_W-1:0]  r_gen;
    logic [GEN_W-1:0]  w_gen_next;
    logic [GEN_W-1:0]  w_gen_inc;
    cause_t            r_cause;
    cause_t            w_cause_next;
    logic              r_gen_valid;
    logic              r_done;
    logic              w_commit;
    logic              w_done_set;
    logic              w_timer_clear;
    logic              w_tick;
    logic              w_running;
    logic              w_stop_req;
    logic              w_start_req;
    logic              w_step_req;
    logic              w_max_hit;

    assign w_running   = (r_state == ST_RUN);
    // Requests meaningless in the current state are ignored and do not
    // block lower-priority requests.
    assign w_stop_req  = bus.stop  && w_running;
    assign w_start_req = bus.start && !w_running;
    assign w_step_req  = bus.step  && !w_running;
    assign w_gen_inc   = r_gen + 1'b1;
    assign w_max_hit   = (bus.max_gen != '0) && (bus.max_gen == w_gen_inc);

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_timer_clear),
        .i_enable (w_running),
        .o_tick   (w_tick)
    );

    // Next state, next grid/count/cause, and pulse requests by request priority.
    always_comb begin
        w_state_next  = r_state;
        w_grid_next   = r_grid;
        w_gen_next    = r_gen;
        w_cause_next  = r_cause;
        w_commit      = 1'b0;
        w_done_set    = 1'b0;
        w_timer_clear = 1'b0;

        if (bus.load) begin
            w_state_next  = ST_IDLE;
            w_grid_next   = bus.seed;
            w_gen_next    = '0;
            w_cause_next  = CAUSE_STOP;
            w_timer_clear = 1'b1;
        end else if (w_stop_req) begin
            w_state_next = ST_HALT;
            w_cause_next = CAUSE_STOP;
            w_done_set   = 1'b1;
        end else if (w_start_req) begin
            w_state_next  = ST_RUN;
            w_cause_next  = CAUSE_STOP;
            w_timer_clear = 1'b1;
        end else if (w_tick) begin
`ifdef GRID_HALT_DETECT_EN
            if (bus.grid_evolve == '0) begin
                w_commit     = 1'b1;
                w_grid_next  = bus.grid_evolve;
                w_gen_next   = w_gen_inc;
                w_state_next = ST_HALT;
                w_cause_next = CAUSE_EXTINCT;
                w_done_set   = 1'b1;
            end else if (bus.grid_evolve == r_grid) begin
                w_state_next = ST_HALT;
                w_cause_next = CAUSE_STABLE;
                w_done_set   = 1'b1;
            end else begin
                w_commit    = 1'b1;
                w_grid_next = bus.grid_evolve;
                w_gen_next  = w_gen_inc;
                if (w_max_hit) begin
                    w_state_next = ST_HALT;
                    w_cause_next = CAUSE_MAXGEN;
                    w_done_set   = 1'b1;
                end
            end
`else
            w_commit    = 1'b1;
            w_grid_next = bus.grid_evolve;
            w_gen_next  = w_gen_inc;
            if (w_max_hit) begin
                w_state_next = ST_HALT;
                w_cause_next = CAUSE_MAXGEN;
                w_done_set   = 1'b1;
            end
`endif
        end else if (w_step_req) begin
            w_commit     = 1'b1;
            w_grid_next  = bus.grid_evolve;
            w_gen_next   = w_gen_inc;
            w_state_next = ST_HALT;
            if (w_max_hit) begin
                w_cause_next = CAUSE_MAXGEN;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grid, generation count, halt cause and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grid      <= '0;
            r_gen       <= '0;
            r_cause     <= CAUSE_STOP;
            r_gen_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_grid      <= w_grid_next;
            r_gen       <= w_gen_next;
            r_cause     <= w_cause_next;
            r_gen_valid <= w_commit;
            r_done      <= w_done_set;
        end
    end

    assign bus.grid       = r_grid;
    assign bus.gen_count  = r_gen;
    assign bus.gen_valid  = r_gen_valid;
    assign bus.busy       = w_running;
    assign bus.done       = r_done;
    assign bus.done_cause = r_cause;

endmodule

// File: tb/tb_grid_sequencer.sv
// Directed bench for grid_sequencer: instance A (STEP_DIV=1) covers reset,
// blinker, max_gen limit, extinct/stable, async reset and single-step;
// instance B (STEP_DIV=4) covers commit cadence and load/stop priority.
// Honours GRID_HALT_DETECT_EN to select the expected halting behaviour.
module tb_grid_sequencer;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    grid_sequencer_if #(.GEN_W(16)) if_a ();
    grid_sequencer_if #(.GEN_W(16)) if_b ();

    grid_sequencer #(.GEN_W(16), .STEP_DIV(1)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    grid_sequencer #(.GEN_W(16), .STEP_DIV(4)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_b)
    );

    // Reference Life rule on a bounded 8x8 board (cells beyond edges are dead).
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int          cnt;
        int          rr;
        int          cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            cnt += int'(g[rr*8+cc]);
                    end
                end
                n[r*8+c] = (cnt == 3) || (cnt == 2 && g[r*8+c]);
            end
        end
        return n;
    endfunction

    assign if_a.grid_evolve = life_next(if_a.grid);
    assign if_b.grid_evolve = life_next(if_b.grid);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        if_a.seed = '0; if_a.load = 0; if_a.start = 0; if_a.stop = 0; if_a.step = 0; if_a.max_gen = '0;
        if_b.seed = '0; if_b.load = 0; if_b.start = 0; if_b.stop = 0; if_b.step = 0; if_b.max_gen = '0;

        // Reset state
        #2;
        check("rst_grid", if_a.grid, 64'h0);
        check("rst_gen", 64'(if_a.gen_count), 64'h0);
        check("rst_gv", 64'(if_a.gen_valid), 64'h0);
        check("rst_busy", 64'(if_a.busy), 64'h0);
        check("rst_done", 64'(if_a.done), 64'h0);
        check("rst_cause", 64'(if_a.done_cause), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Blinker run, then user stop
        if_a.seed = 64'h0E00; if_a.load = 1;
        @(negedge clk); if_a.load = 0;
        check("blk_load_grid", if_a.grid, 64'h0E00);
        check("blk_load_busy", 64'(if_a.busy), 64'h0);
        if_a.start = 1;
        @(negedge clk); if_a.start = 0;
        check("blk_busy", 64'(if_a.busy), 64'h1);
        check("blk_gen0", 64'(if_a.gen_count), 64'h0);
        @(negedge clk);
        check("blk_g1_grid", if_a.grid, 64'h40404);
        check("blk_g1_gen", 64'(if_a.gen_count), 64'h1);
        check("blk_g1_gv", 64'(if_a.gen_valid), 64'h1);
        @(negedge clk);
        check("blk_g2_grid", if_a.grid, 64'h0E00);
        check("blk_g2_gen", 64'(if_a.gen_count), 64'h2);
        check("blk_g2_gv", 64'(if_a.gen_valid), 64'h1);
        if_a.stop = 1;
        @(negedge clk); if_a.stop = 0;
        check("stop_gen", 64'(if_a.gen_count), 64'h2);
        check("stop_grid", if_a.grid, 64'h0E00);
        check("stop_gv", 64'(if_a.gen_valid), 64'h0);
        check("stop_busy", 64'(if_a.busy), 64'h0);
        check("stop_done", 64'(if_a.done), 64'h1);
        check("stop_cause", 64'(if_a.done_cause), 64'h0);
        @(negedge clk);
        check("stop_done_end", 64'(if_a.done), 64'h0);

        // max_gen limit
        if_a.max_gen = 16'd3; if_a.load = 1;
        @(negedge clk); if_a.load = 0; if_a.start = 1;
        @(negedge clk); if_a.start = 0;
        check("lim_busy", 64'(if_a.busy), 64'h1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("lim_gen", 64'(if_a.gen_count), 64'(i));
            check("lim_done", 64'(if_a.done), (i == 3) ? 64'h1 : 64'h0);
        end
        check("lim_cause", 64'(if_a.done_cause), 64'h1);
        check("lim_busy_end", 64'(if_a.busy), 64'h0);
        check("lim_grid", if_a.grid, 64'h40404);
        @(negedge clk);
        check("lim_gen_hold", 64'(if_a.gen_count), 64'h3);
        check("lim_done_end", 64'(if_a.done), 64'h0);
        check("lim_gv_end", 64'(if_a.gen_valid), 64'h0);
        if_a.max_gen = '0;

        // STEP_DIV=4 cadence, then load+stop on a commit cycle
        if_b.seed = 64'h0E00; if_b.load = 1;
        @(negedge clk); if_b.load = 0; if_b.start = 1;
        @(negedge clk); if_b.start = 0;
        check("div_busy", 64'(if_b.busy), 64'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("div_wait_gen", 64'(if_b.gen_count), 64'h0);
        end
        @(negedge clk);
        check("div_c1_gen", 64'(if_b.gen_count), 64'h1);
        check("div_c1_grid", if_b.grid, 64'h40404);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("div_wait2_gen", 64'(if_b.gen_count), 64'h1);
        end
        if_b.seed = 64'h3C; if_b.load = 1; if_b.stop = 1;
        @(negedge clk); if_b.load = 0; if_b.stop = 0;
        check("pri_grid", if_b.grid, 64'h3C);
        check("pri_gen", 64'(if_b.gen_count), 64'h0);
        check("pri_busy", 64'(if_b.busy), 64'h0);
        check("pri_done", 64'(if_b.done), 64'h0);
        check("pri_gv", 64'(if_b.gen_valid), 64'h0);
        @(negedge clk);
        check("pri_done2", 64'(if_b.done), 64'h0);
        check("pri_busy2", 64'(if_b.busy), 64'h0);

        // Extinct pattern
        if_a.seed = 64'h1; if_a.load = 1;
        @(negedge clk); if_a.load = 0; if_a.start = 1;
        @(negedge clk); if_a.start = 0;
`ifdef GRID_HALT_DETECT_EN
        @(negedge clk);
        check("ext_gen", 64'(if_a.gen_count), 64'h1);
        check("ext_grid", if_a.grid, 64'h0);
        check("ext_cause", 64'(if_a.done_cause), 64'h3);
        check("ext_done", 64'(if_a.done), 64'h1);
        check("ext_busy", 64'(if_a.busy), 64'h0);
`else
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("ext_run_gen", 64'(if_a.gen_count), 64'(i));
            check("ext_run_busy", 64'(if_a.busy), 64'h1);
        end
        check("ext_run_grid", if_a.grid, 64'h0);
        if_a.stop = 1;
        @(negedge clk); if_a.stop = 0;
        check("ext_stop_done", 64'(if_a.done), 64'h1);
        check("ext_stop_cause", 64'(if_a.done_cause), 64'h0);
        check("ext_stop_gen", 64'(if_a.gen_count), 64'h3);
`endif

        // Stable block pattern
        if_a.seed = 64'h60600; if_a.load = 1;
        @(negedge clk); if_a.load = 0; if_a.start = 1;
        @(negedge clk); if_a.start = 0;
        @(negedge clk);
`ifdef GRID_HALT_DETECT_EN
        check("stb_gen", 64'(if_a.gen_count), 64'h0);
        check("stb_grid", if_a.grid, 64'h60600);
        check("stb_cause", 64'(if_a.done_cause), 64'h2);
        check("stb_done", 64'(if_a.done), 64'h1);
        check("stb_gv", 64'(if_a.gen_valid), 64'h0);
`else
        check("stb_run_gen", 64'(if_a.gen_count), 64'h1);
        check("stb_run_grid", if_a.grid, 64'h60600);
        check("stb_run_busy", 64'(if_a.busy), 64'h1);
        if_a.stop = 1;
        @(negedge clk); if_a.stop = 0;
        check("stb_stop_cause", 64'(if_a.done_cause), 64'h0);
`endif

        // Asynchronous reset mid-RUN
        if_a.seed = 64'h0E00; if_a.load = 1;
        @(negedge clk); if_a.load = 0; if_a.start = 1;
        @(negedge clk); if_a.start = 0;
        @(negedge clk);
        check("ar_pre_gv", 64'(if_a.gen_valid), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_grid", if_a.grid, 64'h0);
        check("ar_gen", 64'(if_a.gen_count), 64'h0);
        check("ar_gv", 64'(if_a.gen_valid), 64'h0);
        check("ar_busy", 64'(if_a.busy), 64'h0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("ar_rel_done", 64'(if_a.done), 64'h0);
        check("ar_rel_busy", 64'(if_a.busy), 64'h0);

        // Single step from IDLE, then from HALT
        if_a.seed = 64'h0E00; if_a.load = 1;
        @(negedge clk); if_a.load = 0; if_a.step = 1;
        @(negedge clk); if_a.step = 0;
        check("stp1_gen", 64'(if_a.gen_count), 64'h1);
        check("stp1_grid", if_a.grid, 64'h40404);
        check("stp1_gv", 64'(if_a.gen_valid), 64'h1);
        check("stp1_busy", 64'(if_a.busy), 64'h0);
        check("stp1_done", 64'(if_a.done), 64'h0);
        @(negedge clk);
        check("stp1_hold_gen", 64'(if_a.gen_count), 64'h1);
        check("stp1_hold_done", 64'(if_a.done), 64'h0);
        if_a.step = 1;
        @(negedge clk); if_a.step = 0;
        check("stp2_gen", 64'(if_a.gen_count), 64'h2);
        check("stp2_grid", if_a.grid, 64'h0E00);
        check("stp2_done", 64'(if_a.done), 64'h0);
        check("stp2_busy", 64'(if_a.busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/grid_sequencer.md
GRID_SEQUENCER -- requirements
Module: grid_sequencer

Interface
REQ-001 Parameter GEN_W, default 16, SHALL set the width of the generation counter and of max_gen.
REQ-002 Parameter STEP_DIV, default 1 (legal range 1..65535), SHALL set the number of clk cycles between generation commits in RUN.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 seed  in  64  SHALL be the initial pattern, 8x8 row-major, bit r*8+c.
REQ-006 load  in  1  SHALL be a level-sampled request to copy seed into grid.
REQ-007 start, stop, step  in  1 each  SHALL be the run, halt and single-generation requests.
REQ-008 max_gen  in  GEN_W  SHALL be the generation limit; 0 SHALL mean unlimited.
REQ-009 grid_evolve  in  64  SHALL be the combinational next generation of grid, supplied by the downstream evolve datapath.
REQ-010 grid  out  64  SHALL be the registered current generation, driven to the evolve datapath and to the display.
REQ-011 gen_count  out  GEN_W  SHALL be the number of generations committed since the last load.
REQ-012 gen_valid  out  1  SHALL pulse for one cycle in the cycle after each commit.
REQ-013 busy  out  1  SHALL be high exactly while the state is RUN.
REQ-014 done  out  1  SHALL pulse for one cycle on every entry to HALT from RUN.
REQ-015 done_cause  out  2  SHALL hold the halt reason: 00 user stop, 01 max_gen reached, 10 stable, 11 extinct; it SHALL remain valid until the next load or start.

Function
REQ-016 States SHALL be IDLE, RUN and HALT.
REQ-017 Request priority in any single cycle SHALL be load > stop > start > step.
REQ-018 load in any state SHALL set grid to seed, gen_count to 0, done_cause to 00, the step timer to 0, and the state to IDLE.
REQ-019 start in IDLE or HALT SHALL enter RUN and clear the step timer; start in RUN SHALL be ignored.
REQ-020 In RUN, a commit SHALL occur every STEP_DIV cycles, with the first commit STEP_DIV cycles after entry.
REQ-021 A commit SHALL set grid to grid_evolve and gen_count to gen_count+1, with the counter wrapping at 2^GEN_W.
REQ-022 After a commit, if max_gen is nonzero and equals the new gen_count, the block SHALL enter HALT with cause 01.
REQ-023 stop in RUN SHALL enter HALT with cause 00 on the next edge, and no commit SHALL occur in that cycle.
REQ-024 step in IDLE or HALT SHALL perform exactly one commit on the next edge and go to HALT, with no done pulse; step in RUN SHALL be ignored.
REQ-025 Inputs arriving in the same cycle as a commit SHALL follow priority, and load or stop SHALL suppress that commit.
REQ-026 grid_evolve SHALL be sampled only on commit edges.

Reset
REQ-027 While reset_n is low: grid=0, gen_count=0, gen_valid=0, busy=0, done=0, done_cause=00, step timer=0, state=IDLE.
REQ-028 Reset asserted mid-RUN SHALL abort immediately, with no done pulse on release.

Configuration
REQ-029 With GRID_HALT_DETECT_EN defined, at each RUN commit, grid_evolve==0 SHALL commit, then HALT with cause 11 (extinct).
REQ-030 With GRID_HALT_DETECT_EN defined, grid_evolve==grid (nonzero) SHALL NOT commit or count and SHALL HALT with cause 10 (stable).
REQ-031 With GRID_HALT_DETECT_EN defined, extinct SHALL take precedence over stable, and both SHALL take precedence over max_gen.
REQ-032 Without GRID_HALT_DETECT_EN, the block SHALL never produce causes 10 or 11.

Structure
REQ-033 A shared package life_pkg SHALL hold GRID_W=64, the state enum and the halt-cause enum.
REQ-034 A sub-module step_timer SHALL implement the STEP_DIV cycle counter and its commit-tick output.

Verification
REQ-035 Blinker: seed 0x0000_0000_0000_0E00, load, start, STEP_DIV=1 -> gen 1 grid 0x40404, gen 2 grid 0xE00, gen_valid each cycle.
REQ-036 Limit: blinker with max_gen=3 -> exactly 3 commits, then done pulse, cause 01, gen_count=3, busy=0.
REQ-037 Stable (macro on): seed 0x60600, start -> done at first tick, cause 10, gen_count=0, grid unchanged.
REQ-038 Extinct (macro on): seed 0x1, start -> 1 commit, grid=0, cause 11; macro off -> keeps running until stop.
REQ-039 Priority: in RUN with STEP_DIV=4, load and stop asserted on a commit cycle -> no commit, grid=seed, IDLE, no done pulse.
REQ-040 Reset and step: reset_n low mid-RUN -> all outputs 0 asynchronously; then load blinker, step -> one commit, HALT, no done.
